// File: rtl/gpio_pkg.sv
// Shared GPIO definitions, used by the input capture block and the pad interface.
//   GPIO_WIDTH_DEF      : default number of pad bits
//   DEBOUNCE_CYCLES_DEF : default stable cycles before a level change is accepted
//   db_cnt_t            : per-bit debounce counter type
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH_DEF      = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned DB_CNT_W            = 8;

  typedef logic [DB_CNT_W-1:0] db_cnt_t;

endpackage

// File: rtl/gpio_in_debounce.sv
// Per-bit input path: two-flop synchronizer, optional debounce, edge detect.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   i_pad              : raw pad bit (asynchronous to sys_clk)
//   i_db_en            : 1 = debounce, 0 = bypass (level follows synchronizer)
//   o_level            : synchronized, debounced level
//   o_rise / o_fall    : one-cycle pulse, the cycle after o_level changes
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_pad,
  input  logic i_db_en,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam db_cnt_t CNT_MAX = db_cnt_t'(DEBOUNCE_CYCLES - 1);

  logic    r_s1;
  logic    r_s2;
  logic    r_level;
  logic    r_level_d;
  logic    r_db_en_d;
  logic    r_rise;
  logic    r_fall;
  db_cnt_t r_cnt;

  logic    w_level_nxt;
  db_cnt_t w_cnt_nxt;

  // Counter only advances while the synchronized input disagrees with the
  // accepted level; a mode change restarts the count.
  always_comb begin
    w_level_nxt = r_level;
    w_cnt_nxt   = '0;
    if (!i_db_en) begin
      w_level_nxt = r_s2;
    end else if (i_db_en != r_db_en_d) begin
      w_cnt_nxt = '0;
    end else if (r_s2 != r_level) begin
      if (r_cnt == CNT_MAX) begin
        w_level_nxt = r_s2;
      end else begin
        w_cnt_nxt = r_cnt + db_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_db_en_d <= 1'b0;
      r_cnt     <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_s1      <= i_pad;
      r_s2      <= r_s1;
      r_level   <= w_level_nxt;
      r_level_d <= r_level;
      r_db_en_d <= i_db_en;
      r_cnt     <= w_cnt_nxt;
      r_rise    <= r_level & ~r_level_d;
      r_fall    <= ~r_level & r_level_d;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: per-bit synchronize/debounce/edge detect plus sticky
// edge interrupt status.
//   sys_clk, sys_rst_n       : clock, async active-low reset
//   gpio_data_in             : raw pad inputs
//   db_enable                : per-bit debounce enable (0 = bypass)
//   irq_rise_en/irq_fall_en  : per-bit edge interrupt enables
//   irq_clear                : per-bit write-1-to-clear of irq_status
//   gpio_level               : debounced level
//   edge_rise/edge_fall      : one-cycle accepted-edge pulses
//   irq_status, irq          : sticky flags and their OR
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH      = GPIO_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [GPIO_WIDTH-1:0] gpio_data_in,
  input  logic [GPIO_WIDTH-1:0] db_enable,
  input  logic [GPIO_WIDTH-1:0] irq_rise_en,
  input  logic [GPIO_WIDTH-1:0] irq_fall_en,
  input  logic [GPIO_WIDTH-1:0] irq_clear,
  output logic [GPIO_WIDTH-1:0] gpio_level,
  output logic [GPIO_WIDTH-1:0] edge_rise,
  output logic [GPIO_WIDTH-1:0] edge_fall,
  output logic [GPIO_WIDTH-1:0] irq_status,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] w_level;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_fall;
  logic [GPIO_WIDTH-1:0] w_set;
  logic [GPIO_WIDTH-1:0] r_irq_status;

  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_bit
    gpio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .i_pad    (gpio_data_in[g]),
      .i_db_en  (db_enable[g]),
      .o_level  (w_level[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

  assign w_set = (w_rise & irq_rise_en) | (w_fall & irq_fall_en);

  // Clear is applied first so a coincident set wins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_irq_status <= '0;
    end else begin
      r_irq_status <= (r_irq_status & ~irq_clear) | w_set;
    end
  end

  assign gpio_level = w_level;
  assign edge_rise  = w_rise;
  assign edge_fall  = w_fall;
  assign irq_status = r_irq_status;
  assign irq        = |r_irq_status;

endmodule

// File: tb/tb_gpio_in_capture.sv
module tb_gpio_in_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pad, db_en, rise_en, fall_en, clr;
  logic [7:0] level, rise, fall, status;
  logic       irq;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [7:0]  lvl;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic [7:0]  st;
    logic        irq;
  } exp_t;

  exp_t q[$];

  gpio_in_capture #(
    .GPIO_WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .gpio_data_in(pad),
    .db_enable   (db_en),
    .irq_rise_en (rise_en),
    .irq_fall_en (fall_en),
    .irq_clear   (clr),
    .gpio_level  (level),
    .edge_rise   (rise),
    .edge_fall   (fall),
    .irq_status  (status),
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expect the given outputs 'off' rising edges after the current negedge.
  function automatic void push(int unsigned off, string nm, logic [7:0] l,
                               logic [7:0] r, logic [7:0] f, logic [7:0] s);
    exp_t e;
    e.cyc  = cyc + off;
    e.name = nm;
    e.lvl  = l;
    e.rise = r;
    e.fall = f;
    e.st   = s;
    e.irq  = (s != 8'h00);
    q.push_back(e);
  endfunction

  task automatic tick(int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this sample point.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || level !== e.lvl || rise !== e.rise || fall !== e.fall ||
          status !== e.st || irq !== e.irq) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got lvl=%h rise=%h fall=%h st=%h irq=%b exp lvl=%h rise=%h fall=%h st=%h irq=%b",
                 e.name, cyc, e.cyc, level, rise, fall, status, irq,
                 e.lvl, e.rise, e.fall, e.st, e.irq);
      end
    end
  end

  initial begin
    rst_n = 1'b0; pad = '0; db_en = '0; rise_en = '0; fall_en = '0; clr = '0;
    tick(1);
    checks++;
    if (level !== 8'h00 || status !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL direct_reset lvl=%h st=%h irq=%b", level, status, irq);
    end
    push(1, "reset", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Debounced rise, 6 edges to level
    db_en = 8'hFF; rise_en = 8'h01;
    pad = 8'h01;
    push(5, "t1_lvl_early", 8'h00, 8'h00, 8'h00, 8'h00);
    push(6, "t1_lvl",       8'h01, 8'h00, 8'h00, 8'h00);
    push(7, "t1_rise",      8'h01, 8'h01, 8'h00, 8'h00);
    push(8, "t1_irq",       8'h01, 8'h00, 8'h00, 8'h01);
    tick(8);
    checks++;
    if (level !== 8'h01 || status !== 8'h01 || irq !== 1'b1) begin
      errors++;
      $display("FAIL direct_t1 lvl=%h st=%h irq=%b", level, status, irq);
    end
    clr = 8'h01;
    push(1, "t1_clr", 8'h01, 8'h00, 8'h00, 8'h00);
    tick(1);
    clr = 8'h00;

    // Glitch: bit1 high for 3 cycles is rejected
    rise_en = 8'h03;
    pad = 8'h03;
    tick(3);
    pad = 8'h01;
    push(3, "t2_glitch_a", 8'h01, 8'h00, 8'h00, 8'h00);
    push(4, "t2_glitch_b", 8'h01, 8'h00, 8'h00, 8'h00);
    push(6, "t2_glitch_c", 8'h01, 8'h00, 8'h00, 8'h00);
    tick(8);

    // Bypass: 3 edges to level
    rise_en = 8'h00; db_en = 8'h00;
    pad = 8'h00;
    push(3, "t3_fall_lvl",   8'h00, 8'h00, 8'h00, 8'h00);
    push(4, "t3_fall_pulse", 8'h00, 8'h00, 8'h01, 8'h00);
    tick(6);
    pad = 8'hA5;
    push(2, "t3_lvl_early", 8'h00, 8'h00, 8'h00, 8'h00);
    push(3, "t3_lvl",       8'hA5, 8'h00, 8'h00, 8'h00);
    push(4, "t3_rise",      8'hA5, 8'hA5, 8'h00, 8'h00);
    push(5, "t3_rise_end",  8'hA5, 8'h00, 8'h00, 8'h00);
    tick(6);

    // Fall-only interrupt on bit7
    db_en = 8'hFF;
    pad = 8'h00;
    push(10, "t4_idle", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(10);
    fall_en = 8'h80;
    pad = 8'h80;
    push(6, "t4_rise_lvl",    8'h80, 8'h00, 8'h00, 8'h00);
    push(7, "t4_rise_pulse",  8'h80, 8'h80, 8'h00, 8'h00);
    push(8, "t4_rise_nostat", 8'h80, 8'h00, 8'h00, 8'h00);
    tick(9);
    pad = 8'h00;
    push(6, "t4_fall_lvl",   8'h00, 8'h00, 8'h00, 8'h00);
    push(7, "t4_fall_pulse", 8'h00, 8'h00, 8'h80, 8'h00);
    push(8, "t4_fall_stat",  8'h00, 8'h00, 8'h00, 8'h80);
    tick(9);
    clr = 8'h80;
    push(1, "t4_clr", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(1);
    checks++;
    if (status !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL direct_t4_clr st=%h irq=%b", status, irq);
    end
    clr = 8'h00;

    // Set wins over coincident clear on bit2
    rise_en = 8'h04; fall_en = 8'h04;
    pad = 8'h04;
    push(8, "t5_set", 8'h04, 8'h00, 8'h00, 8'h04);
    tick(9);
    pad = 8'h00;
    push(7, "t5_fall", 8'h00, 8'h00, 8'h04, 8'h04);
    tick(7);
    clr = 8'h04;
    push(1, "t5_set_wins", 8'h00, 8'h00, 8'h00, 8'h04);
    tick(1);
    push(1, "t5_clr", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(1);
    clr = 8'h00;

    // Reset mid-count with all status bits set
    rise_en = 8'hFF; fall_en = 8'h00;
    pad = 8'hFF;
    push(8, "t6_all_set", 8'hFF, 8'h00, 8'h00, 8'hFF);
    tick(9);
    pad = 8'h00;
    push(3, "t6_pre_rst", 8'hFF, 8'h00, 8'h00, 8'hFF);
    tick(4);
    rst_n = 1'b0;
    push(1, "t6_in_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(2);
    rst_n = 1'b1;
    push(3, "t6_post_a", 8'h00, 8'h00, 8'h00, 8'h00);
    push(6, "t6_post_b", 8'h00, 8'h00, 8'h00, 8'h00);
    push(8, "t6_post_c", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(9);

    // Pad high across reset release reports a normal rise
    rst_n = 1'b0;
    pad = 8'h01; rise_en = 8'h01;
    tick(2);
    rst_n = 1'b1;
    push(5, "t7_lvl_early", 8'h00, 8'h00, 8'h00, 8'h00);
    push(6, "t7_lvl",       8'h01, 8'h00, 8'h00, 8'h00);
    push(7, "t7_rise",      8'h01, 8'h01, 8'h00, 8'h00);
    push(8, "t7_irq",       8'h01, 8'h00, 8'h00, 8'h01);
    tick(10);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never sampled exp cyc=%0d now=%0d", e.name, e.cyc, cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_in_capture.md
GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
REQ-001 Parameter GPIO_WIDTH, default 8: number of pad input bits handled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, legal range 1..255: consecutive stable cycles required before a level change is accepted.
REQ-003 sys_clk  input  1  single system clock; all state updates on rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 gpio_data_in  input  GPIO_WIDTH  raw pad read-back from the pad interface; asynchronous to sys_clk.
REQ-006 db_enable  input  GPIO_WIDTH  per-bit debounce enable; 0 selects bypass.
REQ-007 irq_rise_en  input  GPIO_WIDTH  per-bit rising-edge interrupt enable.
REQ-008 irq_fall_en  input  GPIO_WIDTH  per-bit falling-edge interrupt enable.
REQ-009 irq_clear  input  GPIO_WIDTH  per-bit write-1-to-clear pulse for irq_status.
REQ-010 gpio_level  output  GPIO_WIDTH  synchronized, debounced pin level.
REQ-011 edge_rise  output  GPIO_WIDTH  one-cycle pulse per accepted 0->1 transition.
REQ-012 edge_fall  output  GPIO_WIDTH  one-cycle pulse per accepted 1->0 transition.
REQ-013 irq_status  output  GPIO_WIDTH  sticky per-bit interrupt flags.
REQ-014 irq  output  1  OR-reduction of irq_status.

Function
REQ-015 Each bit of gpio_data_in SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-016 Bypass (db_enable[i]=0): gpio_level[i] SHALL load s2[i] every edge; pad change visible on gpio_level after 3 edges.
REQ-017 Debounce (db_enable[i]=1): per-bit counter increments on each edge where s2[i]!=gpio_level[i]; clears to 0 on any edge where they are equal.
REQ-018 When the counter equals DEBOUNCE_CYCLES-1 and s2[i]!=gpio_level[i], gpio_level[i] SHALL load s2[i] and the counter SHALL clear; total latency is 2+DEBOUNCE_CYCLES edges (6 at default).
REQ-019 Counter width SHALL be 8 bits; the counter never exceeds DEBOUNCE_CYCLES-1 (no wrap).
REQ-020 Toggling db_enable[i] SHALL clear the bit's counter on the same edge.
REQ-021 edge_rise[i]/edge_fall[i] SHALL be registered, asserted for exactly one cycle, in the cycle after gpio_level[i] changes 1 edge earlier (i.e. coincident with the first cycle gpio_level shows the new value +1 edge).
REQ-022 irq_status[i] SHALL set on (edge_rise[i]&irq_rise_en[i]) | (edge_fall[i]&irq_fall_en[i]) and clear on irq_clear[i]; set wins when both occur in the same cycle.
REQ-023 Disabling an enable SHALL NOT clear an already-set irq_status bit.
REQ-024 irq SHALL be combinational OR of registered irq_status, no additional latency.
REQ-025 Bits SHALL operate fully independently; no cross-bit interaction.

Reset
REQ-026 sys_rst_n low SHALL immediately clear s1, s2, counters, gpio_level, edge_rise, edge_fall, irq_status, irq, regardless of operation in progress.
REQ-027 A pad held high across reset release SHALL be reported as a normal rising edge after 2+DEBOUNCE_CYCLES edges (or 3 in bypass).

Structure
REQ-028 GPIO_WIDTH default and DEBOUNCE_CYCLES default SHALL live in shared package gpio_pkg, also used by the pad interface.
REQ-029 Per-bit synchronizer+debounce+edge logic SHALL be one sub-module, gpio_in_debounce, instantiated GPIO_WIDTH times via generate; interrupt status stays in the top.

Verification
REQ-030 Debounce on, pad 0x00->0x01, irq_rise_en=0x01 -> gpio_level=0x01 exactly 6 edges later, edge_rise=0x01 one cycle, irq_status=0x01, irq=1.
REQ-031 Glitch: pad bit1 high for 3 cycles then low, debounce on -> gpio_level, edge_rise, irq_status stay 0x00.
REQ-032 Bypass: db_enable=0x00, pad 0x00->0xA5 -> gpio_level=0xA5 after 3 edges, edge_rise=0xA5 one cycle.
REQ-033 Only irq_fall_en=0x80: bit7 rise -> irq_status 0x00; bit7 fall -> irq_status=0x80, irq=1; irq_clear=0x80 -> irq_status=0x00, irq=0 next cycle.
REQ-034 irq_clear=0x04 in same cycle as new enabled edge on bit2 -> irq_status[2] remains 1.
REQ-035 sys_rst_n pulsed low mid-count (counter=2) with status=0xFF -> all outputs 0x00 during reset, no edge pulse after release if pad=0.
